// File: rtl/ram2_ctrl.sv
// ram2_ctrl: single-port asynchronous SRAM controller shared by an
// instruction-fetch port and a data port. Data accesses win over fetches.
// Each access is fully sequenced (read, or setup/pulse/hold write) and
// finishes with a one-cycle ACK state that pulses the matching ack.
module ram2_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       inst,
    output logic              if_ack,
    // data port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    // pipeline
    output logic              stall_req,
    // SRAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK
    } state_t;

    // Counter value on the final cycle of a RD or WR_PULSE phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                fetch_q, fetch_d;
    logic [31:0]         inst_q, inst_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;

    // Byte-address bits above the SRAM word range and the byte offset are
    // deliberately dropped so addresses wrap; fold them into a sink signal.
    generate
        if (ADDR_W < 30) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], mem_addr[31:ADDR_W+2],
                                        if_addr[1:0], mem_addr[1:0]};
        end else begin : g_unused_lo
            logic unused_addr_bits;
            assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};
        end
    endgenerate

    // State register and access latches; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            fetch_q     <= 1'b0;
            inst_q      <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fetch_q     <= fetch_d;
            inst_q      <= inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state logic: arbitration in IDLE, wait counting in RD/WR_PULSE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fetch_d     = fetch_q;
        inst_d      = inst_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (mem_req) begin
                    addr_d  = mem_addr[ADDR_W+1:2];
                    wdata_d = mem_wdata;
                    fetch_d = 1'b0;
                    state_d = mem_we ? WR_SETUP : RD;
                end else if (if_req) begin
                    addr_d  = if_addr[ADDR_W+1:2];
                    fetch_d = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 4'd0;
                    if (fetch_q) begin
                        inst_d = ram_rdata;
                    end else begin
                        mem_rdata_d = ram_rdata;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = 4'd0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HOLD: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe and ack decode from the registered state; we_n and oe_n are
    // asserted in disjoint states so they can never overlap.
    always_comb begin
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_data_oe = 1'b0;
        if_ack      = 1'b0;
        mem_ack     = 1'b0;
        case (state_q)
            RD: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
            end
            WR_PULSE: begin
                ram_ce_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_data_oe = 1'b1;
            end
            ACK: begin
                if_ack  = fetch_q;
                mem_ack = ~fetch_q;
            end
            default: begin
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign inst      = inst_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_req = (mem_req & ~mem_ack) | (if_req & ~if_ack);

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed bench for ram2_ctrl with WAIT_CYCLES=1 and a small SRAM model.
`timescale 1ns/1ps
module tb_ram2_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       inst;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              stall_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_data_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] sram [0:63];
    logic        init_done;

    ram2_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .inst       (inst),
        .if_ack     (if_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall_req  (stall_req),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_data_oe(ram_data_oe),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: preload pattern, then write while ce_n and we_n are low.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) sram[i] <= 32'(i) * 32'h0101_0101;
            sram[1] <= 32'h1111_2222;
            sram[4] <= 32'h3C01_1234;
            sram[5] <= 32'h55AA_0F0F;
        end else if (!ram_ce_n && !ram_we_n) begin
            sram[ram_addr[5:0]] <= ram_wdata;
        end
    end

    // Read data only valid while the chip is selected with outputs enabled.
    assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[5:0]] : 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One access: request raised just after a rising edge; cycle n is the
    // n-th cycle after the sampling edge. Request drops after the ack cycle.
    task automatic run_acc(input bit is_mem, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit release_rst,
                           output int ack_at, output int oe_cnt, output int we_cnt,
                           output int viol, output logic [ADDR_W-1:0] addr_seen);
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b1;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        ack_at = -1; oe_cnt = 0; we_cnt = 0; viol = 0; addr_seen = '0;
        @(negedge clk);
        if (!stall_req) viol++;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) addr_seen = ram_addr;
            if (!ram_oe_n) oe_cnt++;
            if (!ram_we_n) we_cnt++;
            if (!ram_we_n && (!ram_data_oe || !ram_oe_n || ram_ce_n)) viol++;
            if (ram_data_oe && !ram_oe_n) viol++;
            if (is_mem ? if_ack : mem_ack) viol++;
            if (is_mem ? mem_ack : if_ack) begin
                ack_at = n;
                if (stall_req) viol++;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        if_req  = 1'b0;
        @(negedge clk);
        if (mem_ack || if_ack || !ram_ce_n) viol++;
    endtask

    initial begin
        int ack_at, oe_cnt, we_cnt, viol;
        logic [ADDR_W-1:0] aseen;
        int mack, iack, st_cnt, a1, a2;
        logic [ADDR_W-1:0] a5;
        logic [31:0] d1, d2;
        bit drop;

        rst = 1'b0; init_done = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
        check("rst_acks", {if_ack, mem_ack, stall_req}, 3'b000);
        check("rst_addr", ram_addr, 0);
        check("rst_data", {inst, mem_rdata, ram_wdata}, 96'h0);
        init_done = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;

        // Fetch from byte 0x10 -> word 4
        run_acc(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, ack_at, oe_cnt, we_cnt, viol, aseen);
        $display("fetch 0x10: ack@%0d oe=%0d we=%0d inst=0x%08h", ack_at, oe_cnt, we_cnt, inst);
        check("fetch_ack_cyc", ack_at, 3);
        check("fetch_oe_cnt", oe_cnt, 2);
        check("fetch_we_cnt", we_cnt, 0);
        check("fetch_addr", aseen, 4);
        check("fetch_viol", viol, 0);
        check("fetch_inst", inst, 32'h3C01_1234);

        // Write 0xDEADBEEF to byte 0x8 -> word 2
        run_acc(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, ack_at, oe_cnt, we_cnt, viol, aseen);
        $display("write 0x8: ack@%0d oe=%0d we=%0d sram[2]=0x%08h", ack_at, oe_cnt, we_cnt, sram[2]);
        check("wr_ack_cyc", ack_at, 5);
        check("wr_we_cnt", we_cnt, 2);
        check("wr_oe_cnt", oe_cnt, 0);
        check("wr_addr", aseen, 2);
        check("wr_viol", viol, 0);
        check("wr_sram", sram[2], 32'hDEAD_BEEF);
        check("wr_rdata_kept", mem_rdata, 32'h0);

        // Read back byte 0x8
        run_acc(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, ack_at, oe_cnt, we_cnt, viol, aseen);
        $display("read 0x8: ack@%0d rdata=0x%08h", ack_at, mem_rdata);
        check("rd_ack_cyc", ack_at, 3);
        check("rd_oe_cnt", oe_cnt, 2);
        check("rd_viol", viol, 0);
        check("rd_data", mem_rdata, 32'hDEAD_BEEF);
        check("rd_inst_kept", inst, 32'h3C01_1234);

        // Wrap: high address bits ignored
        run_acc(1'b1, 1'b0, 32'h0040_0004, 32'h0, 1'b0, ack_at, oe_cnt, we_cnt, viol, aseen);
        $display("read 0x00400004: addr=0x%05h rdata=0x%08h", aseen, mem_rdata);
        check("wrap_addr", aseen, 1);
        check("wrap_data", mem_rdata, 32'h1111_2222);
        check("wrap_viol", viol, 0);

        // Contention: data read at 0x4 beats fetch at 0x14
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h0000_0014;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0004;
        mack = -1; iack = -1; st_cnt = 0; a5 = '0; d1 = 32'h0; d2 = 32'h0; drop = 1'b0;
        @(negedge clk);
        if (stall_req) st_cnt++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (drop) mem_req = 1'b0;
            @(negedge clk);
            if (stall_req) st_cnt++;
            if (n == 5) a5 = ram_addr;
            if (mem_ack) begin mack = n; drop = 1'b1; d1 = mem_rdata; end
            if (if_ack) begin iack = n; d2 = inst; break; end
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        $display("contention: mem_ack@%0d if_ack@%0d stall_cycles=%0d", mack, iack, st_cnt);
        check("cont_mem_ack", mack, 3);
        check("cont_if_ack", iack, 7);
        check("cont_stall", st_cnt, 7);
        check("cont_fetch_addr", a5, 5);
        check("cont_mem_data", d1, 32'h1111_2222);
        check("cont_inst", d2, 32'h55AA_0F0F);

        // Reset during WR_PULSE, then held request replays the write
        @(posedge clk);
        #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_000C; mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        check("rstw_setup", {ram_data_oe, ram_we_n}, 2'b11);
        @(negedge clk);
        check("rstw_pulse", {ram_data_oe, ram_we_n}, 2'b10);
        #1 rst = 1'b0;
        #1 check("rstw_abort", {ram_we_n, ram_data_oe, ram_ce_n, mem_ack}, 4'b1010);
        repeat (2) @(negedge clk);
        check("rstw_no_ack", {mem_ack, if_ack}, 2'b00);
        check("rstw_rdata_clr", mem_rdata, 32'h0);
        check("rstw_sram_untouched", sram[3], 32'h0303_0303);
        run_acc(1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b1, ack_at, oe_cnt, we_cnt, viol, aseen);
        $display("replay write 0xC: ack@%0d we=%0d sram[3]=0x%08h", ack_at, we_cnt, sram[3]);
        check("replay_ack_cyc", ack_at, 5);
        check("replay_we_cnt", we_cnt, 2);
        check("replay_viol", viol, 0);
        check("replay_sram", sram[3], 32'hCAFE_F00D);

        // Back-to-back reads with mem_req held: 0x10 then 0x8
        @(posedge clk);
        #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0010;
        a1 = -1; a2 = -1; d1 = 32'h0; d2 = 32'h0; drop = 1'b0;
        @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (drop) begin mem_addr = 32'h0000_0008; drop = 1'b0; end
            @(negedge clk);
            if (mem_ack && a1 < 0) begin
                a1 = n; d1 = mem_rdata; drop = 1'b1;
            end else if (mem_ack) begin
                a2 = n; d2 = mem_rdata; break;
            end
        end
        @(posedge clk);
        #1 mem_req = 1'b0;
        $display("b2b: ack1@%0d data=0x%08h ack2@%0d data=0x%08h", a1, d1, a2, d2);
        check("b2b_ack1", a1, 3);
        check("b2b_ack2", a2, 7);
        check("b2b_data1", d1, 32'h3C01_1234);
        check("b2b_data2", d2, 32'hDEAD_BEEF);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram2_ctrl.md
RAM2_CTRL -- requirements
Module: ram2_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra SRAM access cycles (0..15).
REQ-003 SHALL have port clk input 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst input 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports if_req input 1 and if_addr input 32: instruction-fetch request and byte address.
REQ-006 SHALL have ports inst output 32 and if_ack output 1: fetched word and one-cycle fetch-done pulse.
REQ-007 SHALL have ports mem_req input 1, mem_we input 1, mem_addr input 32 and mem_wdata input 32: data-access request, write select, byte address and write word.
REQ-008 SHALL have ports mem_rdata output 32 and mem_ack output 1: read word and one-cycle data-done pulse.
REQ-009 SHALL have port stall_req output 1, pipeline stall request.
REQ-010 SHALL have ports ram_addr output ADDR_W, ram_wdata output 32, ram_rdata input 32 and ram_data_oe output 1 (1 = controller drives the data bus).
REQ-011 SHALL have ports ram_ce_n output 1, ram_oe_n output 1 and ram_we_n output 1: active-low SRAM strobes.

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and ACK.
REQ-013 In IDLE, on mem_req=1 SHALL latch mem_addr, mem_we and mem_wdata and go to WR_SETUP if mem_we=1, else RD; data requests always take priority over fetch.
REQ-014 In IDLE, with mem_req=0 and if_req=1, SHALL latch if_addr and go to RD as a fetch; with no request it SHALL stay in IDLE.
REQ-015 ram_addr SHALL be the latched byte address bits [ADDR_W+1:2]; higher bits are ignored, so addresses wrap.
REQ-016 RD: ce_n=0, oe_n=0, we_n=1, data_oe=0 for exactly WAIT_CYCLES+1 cycles, counted by an internal counter.
REQ-017 On the last RD edge, ram_rdata SHALL be registered into inst (fetch) or mem_rdata (data), and the FSM SHALL go to ACK.
REQ-018 WR_SETUP (1 cycle): ce_n=0, we_n=1, oe_n=1, data_oe=1, ram_wdata = latched data.
REQ-019 WR_PULSE (WAIT_CYCLES+1 cycles): as WR_SETUP but we_n=0.
REQ-020 WR_HOLD (1 cycle): we_n=1, ce_n=0, data_oe=1 and ram_wdata still driven; then go to ACK.
REQ-021 ACK (1 cycle): all strobes inactive, data_oe=0; exactly one of if_ack or mem_ack SHALL be 1, matching the latched requester; then go to IDLE.
REQ-022 Read latency: request sampled in IDLE at edge k gives ack high in the cycle after edge k+WAIT_CYCLES+1. Write latency: ack high in the cycle after edge k+WAIT_CYCLES+3.
REQ-023 inst and mem_rdata SHALL hold their value until the next read of the same kind; a write SHALL never modify mem_rdata.
REQ-024 Request inputs SHALL be ignored outside IDLE; changes mid-access have no effect on the access in flight.
REQ-025 Requesters hold req until their ack; a req still high in the cycle after ACK SHALL start a new access (back-to-back, one IDLE cycle between).
REQ-026 stall_req SHALL be combinational: (mem_req & ~mem_ack) | (if_req & ~if_ack).
REQ-027 ram_data_oe=1 SHALL occur only in WR_SETUP, WR_PULSE or WR_HOLD; we_n=0 only in WR_PULSE; we_n=0 and oe_n=0 SHALL never coincide.

Reset
REQ-028 With rst=0, asynchronously: state=IDLE, counter=0, ce_n=oe_n=we_n=1, data_oe=0, ram_addr=0, ram_wdata=0, inst=0, mem_rdata=0, if_ack=mem_ack=0.
REQ-029 Reset asserted mid-access SHALL abort the access with no ack; after release the FSM restarts from IDLE and resamples requests.

Verification (WAIT_CYCLES=1)
REQ-030 Fetch: if_req=1, if_addr=0x0000_0010, SRAM word 4=0x3C01_1234 -> ram_addr=4, oe_n low 2 cycles, if_ack pulse 3rd cycle, inst=0x3C01_1234.
REQ-031 Write: mem_req=1, mem_we=1, mem_addr=0x8, mem_wdata=0xDEAD_BEEF -> ram_addr=2, we_n low exactly 2 cycles inside data_oe window, mem_ack in 5th cycle.
REQ-032 Contention: if_req and mem_req (read, addr 0x4) raised together -> data read served first with mem_ack; fetch starts the cycle after ACK; stall_req stays 1 until if_ack.
REQ-033 Wrap: mem_addr=0x0040_0004 read -> ram_addr=0x00001.
REQ-034 Reset mid-write: rst=0 during WR_PULSE -> we_n=1 and data_oe=0 immediately, no mem_ack; after release a held mem_req replays the full write.
REQ-035 Back-to-back: mem_req held across two reads -> exactly one IDLE cycle between the two mem_ack pulses, each with the correct data.
